// File: rtl/dsp_pipe_ctrl.sv
// dsp_pipe_ctrl: valid/ready flow control for the DSP slice pipeline registers.
// Generates per-stage clock enables with bubble collapse, tracks a valid bit per
// registered stage, and reports how many items are held in the pipe.
module dsp_pipe_ctrl #(
    parameter int                STAGES     = 4,
    parameter logic [STAGES-1:0] STAGE_MASK = {STAGES{1'b1}},
    parameter int                OCC_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STAGES-1:0] ce,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] vld_pipe;   // valid bit per registered stage (bypassed bits stay 0)
    logic [STAGES-1:0] vld_nxt;
    logic [STAGES-1:0] vin;        // valid presented at each stage input
    logic [STAGES-1:0] rdy;        // stage i can accept this cycle
    logic [OCC_W-1:0]  occ_nxt;
    logic              blk;        // reset or flush: freeze all transfers this cycle

    assign blk = !rst_n || flush;

    // Forward valid chain; bypassed stages pass their input valid straight through.
    always_comb begin : valid_chain
        logic v_run;
        v_run = in_valid;
        vin   = '0;
        for (int i = 0; i < STAGES; i++) begin
            vin[i] = v_run;
            if (STAGE_MASK[i]) v_run = vld_pipe[i];
        end
        out_valid = v_run && !blk;
    end

    // Backward ready chain; an empty registered stage is always ready (bubble collapse).
    always_comb begin : ready_chain
        logic r_run;
        r_run = out_ready;
        rdy   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (STAGE_MASK[i]) r_run = !vld_pipe[i] || r_run;
            rdy[i] = r_run;
        end
        in_ready = r_run && !blk;
    end

    assign ce = rdy & STAGE_MASK & {STAGES{!blk}};

    // Next valid state and its population count for the registered occupancy.
    always_comb begin : next_state
        vld_nxt = vld_pipe;
        occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (ce[i]) vld_nxt[i] = vin[i];
        end
        vld_nxt = vld_nxt & STAGE_MASK;
        for (int i = 0; i < STAGES; i++) begin
            occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
        end
    end

    // Valid bits and occupancy; reset and flush both empty the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_pipe  <= '0;
            occupancy <= '0;
        end else begin
            vld_pipe  <= vld_nxt;
            occupancy <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// tb_dsp_pipe_ctrl: directed checks of dsp_pipe_ctrl with a full mask, a sparse
// mask (4'b0101) and an all-bypass mask, sharing one stimulus stream. Small data
// registers clocked by each instance's ce stand in for the slice datapath so
// ordering can be checked against hand-computed values.
module tb_dsp_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, out_ready;
    logic [7:0] din;

    logic       m_in_ready, m_out_valid, s_in_ready, s_out_valid, b_in_ready, b_out_valid;
    logic [3:0] m_ce, s_ce, b_ce;
    logic [2:0] m_occ, s_occ, b_occ;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsp_pipe_ctrl #(.STAGES(4), .STAGE_MASK(4'b1111)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .out_valid(m_out_valid), .out_ready(out_ready), .ce(m_ce), .occupancy(m_occ));

    dsp_pipe_ctrl #(.STAGES(4), .STAGE_MASK(4'b0101)) u_sp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .ce(s_ce), .occupancy(s_occ));

    dsp_pipe_ctrl #(.STAGES(4), .STAGE_MASK(4'b0000)) u_byp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .ce(b_ce), .occupancy(b_occ));

    // Datapath stand-ins: registers that load only on their stage enable.
    logic [7:0] m_d [4];
    logic [7:0] s_d0, s_d2;
    always @(posedge clk) begin
        if (m_ce[0]) m_d[0] <= din;
        for (int i = 1; i < 4; i++) if (m_ce[i]) m_d[i] <= m_d[i-1];
        if (s_ce[0]) s_d0 <= din;
        if (s_ce[2]) s_d2 <= s_d0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, checking forced outputs and cleared state.
    task automatic do_reset;
        tick();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; din = 8'h00;
        #1;
        n_chk++; if (m_ce !== 4'b0000) begin n_fail++; $display("FAIL rst_ce got %b exp 0000", m_ce); end
        n_chk++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", m_in_ready); end
        n_chk++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_bypass got v=%b r=%b exp 0 0", b_out_valid, b_in_ready); end
        tick();
        n_chk++; if (m_occ !== 3'd0 || s_occ !== 3'd0) begin n_fail++; $display("FAIL rst_occ got %0d/%0d exp 0", m_occ, s_occ); end
        n_chk++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", m_out_valid); end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        n_chk++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b exp 1", m_in_ready); end
        n_chk++; if (m_ce !== 4'b1111) begin n_fail++; $display("FAIL post_rst_ce got %b exp 1111", m_ce); end
        n_chk++; if (s_ce !== 4'b0101) begin n_fail++; $display("FAIL post_rst_sp_ce got %b exp 0101", s_ce); end
    endtask

    // D0..D7 back to back with the consumer always ready.
    task automatic test_fill;
        logic       ev_m, ev_s;
        logic [7:0] ed;
        int         occ;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            tick();
            in_valid = (c < 8); out_ready = 1'b1; din = 8'hD0 + 8'(c);
            #1;
            ev_m = (c >= 4 && c < 12);
            ev_s = (c >= 2 && c < 10);
            occ  = ((c < 8) ? c : 8) - ((c > 4) ? (((c < 12) ? c : 12) - 4) : 0);
            n_chk++; if (m_out_valid !== ev_m) begin n_fail++; $display("FAIL fill_valid c=%0d got %b exp %b", c, m_out_valid, ev_m); end
            if (ev_m) begin
                ed = 8'hD0 + 8'(c - 4);
                n_chk++; if (m_d[3] !== ed) begin n_fail++; $display("FAIL fill_data c=%0d got %h exp %h", c, m_d[3], ed); end
            end
            n_chk++; if (m_occ !== 3'(occ)) begin n_fail++; $display("FAIL fill_occ c=%0d got %0d exp %0d", c, m_occ, occ); end
            n_chk++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready c=%0d got %b exp 1", c, m_in_ready); end
            n_chk++; if (s_out_valid !== ev_s) begin n_fail++; $display("FAIL sp_fill_valid c=%0d got %b exp %b", c, s_out_valid, ev_s); end
            if (ev_s) begin
                ed = 8'hD0 + 8'(c - 2);
                n_chk++; if (s_d2 !== ed) begin n_fail++; $display("FAIL sp_fill_data c=%0d got %h exp %h", c, s_d2, ed); end
            end
            n_chk++; if (b_out_valid !== in_valid || b_in_ready !== out_ready || b_occ !== 3'd0)
                begin n_fail++; $display("FAIL bypass c=%0d got v=%b r=%b o=%0d exp %b %b 0", c, b_out_valid, b_in_ready, b_occ, in_valid, out_ready); end
        end
    endtask

    // Stall the consumer with input held valid, then release for one cycle, then drain.
    task automatic test_backpressure;
        logic [7:0] ed;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            in_valid = 1'b1; out_ready = 1'b0; din = 8'hA0 + 8'(c);
            #1;
            n_chk++; if (m_in_ready !== (c < 4)) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b exp %b", c, m_in_ready, (c < 4)); end
            n_chk++; if (m_occ !== 3'((c < 4) ? c : 4)) begin n_fail++; $display("FAIL bp_occ c=%0d got %0d", c, m_occ); end
            n_chk++; if (s_in_ready !== (c < 2)) begin n_fail++; $display("FAIL sp_bp_in_ready c=%0d got %b exp %b", c, s_in_ready, (c < 2)); end
            n_chk++; if (s_ce[1] !== 1'b0 || s_ce[3] !== 1'b0) begin n_fail++; $display("FAIL sp_ce_bypass c=%0d got %b", c, s_ce); end
            n_chk++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL bypass_bp c=%0d got %b exp 0", c, b_in_ready); end
        end
        n_chk++; if (m_ce !== 4'b0000) begin n_fail++; $display("FAIL bp_full_ce got %b exp 0000", m_ce); end
        n_chk++; if (s_occ !== 3'd2) begin n_fail++; $display("FAIL sp_bp_occ got %0d exp 2", s_occ); end
        tick();
        in_valid = 1'b1; out_ready = 1'b1; din = 8'hA7;
        #1;
        n_chk++; if (m_in_ready !== 1'b1 || m_ce !== 4'b1111) begin n_fail++; $display("FAIL bp_release got r=%b ce=%b exp 1 1111", m_in_ready, m_ce); end
        n_chk++; if (m_out_valid !== 1'b1 || m_d[3] !== 8'hA0) begin n_fail++; $display("FAIL bp_release_out got v=%b d=%h exp 1 a0", m_out_valid, m_d[3]); end
        n_chk++; if (s_in_ready !== 1'b1 || s_d2 !== 8'hA0) begin n_fail++; $display("FAIL sp_release got r=%b d=%h exp 1 a0", s_in_ready, s_d2); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_chk++; if (m_occ !== 3'd4 || m_in_ready !== 1'b0 || m_d[3] !== 8'hA1)
            begin n_fail++; $display("FAIL bp_after got occ=%0d r=%b d=%h exp 4 0 a1", m_occ, m_in_ready, m_d[3]); end
        n_chk++; if (s_occ !== 3'd2 || s_d2 !== 8'hA1) begin n_fail++; $display("FAIL sp_after got occ=%0d d=%h exp 2 a1", s_occ, s_d2); end
        for (int c = 0; c < 4; c++) begin
            tick();
            out_ready = 1'b1;
            #1;
            case (c)
                0: ed = 8'hA1; 1: ed = 8'hA2; 2: ed = 8'hA3; default: ed = 8'hA7;
            endcase
            n_chk++; if (m_out_valid !== 1'b1 || m_d[3] !== ed) begin n_fail++; $display("FAIL bp_drain c=%0d got v=%b d=%h exp 1 %h", c, m_out_valid, m_d[3], ed); end
            if (c == 1) begin
                n_chk++; if (s_out_valid !== 1'b1 || s_d2 !== 8'hA7) begin n_fail++; $display("FAIL sp_drain got v=%b d=%h exp 1 a7", s_out_valid, s_d2); end
            end
        end
    endtask

    // A, idle, B with the consumer stalled: B must close the gap behind A.
    task automatic test_bubble;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            out_ready = 1'b0;
            in_valid  = (c == 0 || c == 2);
            din       = (c == 0) ? 8'hAA : 8'hBB;
            #1;
            n_chk++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready c=%0d got %b exp 1", c, m_in_ready); end
        end
        n_chk++; if (m_out_valid !== 1'b1 || m_d[3] !== 8'hAA) begin n_fail++; $display("FAIL bub_a got v=%b d=%h exp 1 aa", m_out_valid, m_d[3]); end
        n_chk++; if (m_d[2] !== 8'hBB) begin n_fail++; $display("FAIL bub_b got %h exp bb", m_d[2]); end
        n_chk++; if (m_occ !== 3'd2 || m_ce !== 4'b0011) begin n_fail++; $display("FAIL bub_state got occ=%0d ce=%b exp 2 0011", m_occ, m_ce); end
    endtask

    // Three items in flight, one flush cycle, nothing may come out afterwards.
    task automatic test_flush;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            out_ready = 1'b0; in_valid = (c < 3); din = 8'hF0 + 8'(c);
        end
        tick();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_chk++; if (m_occ !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got %0d exp 3", m_occ); end
        n_chk++; if (m_in_ready !== 1'b0 || m_out_valid !== 1'b0 || m_ce !== 4'b0000)
            begin n_fail++; $display("FAIL flush_cycle got r=%b v=%b ce=%b exp 0 0 0000", m_in_ready, m_out_valid, m_ce); end
        n_chk++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL sp_flush_valid got %b exp 0", s_out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_chk++; if (m_occ !== 3'd0 || s_occ !== 3'd0) begin n_fail++; $display("FAIL flush_occ got %0d/%0d exp 0", m_occ, s_occ); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_chk++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak c=%0d got %b exp 0", c, m_out_valid); end
        end
    endtask

    // Fill the pipe, pulse reset for one cycle, then one fresh item with 4-cycle latency.
    task automatic test_reset_mid;
        logic ev;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            out_ready = 1'b0; in_valid = 1'b1; din = 8'h40 + 8'(c);
        end
        tick();
        rst_n = 1'b0; out_ready = 1'b1;
        #1;
        n_chk++; if (m_ce !== 4'b0000 || m_in_ready !== 1'b0 || m_out_valid !== 1'b0)
            begin n_fail++; $display("FAIL midrst got ce=%b r=%b v=%b exp 0000 0 0", m_ce, m_in_ready, m_out_valid); end
        for (int r = 0; r < 8; r++) begin
            tick();
            rst_n = 1'b1; in_valid = (r == 0); din = 8'h5E;
            #1;
            if (r == 0) begin
                n_chk++; if (m_occ !== 3'd0 || m_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_after got occ=%0d r=%b exp 0 1", m_occ, m_in_ready); end
            end
            ev = (r == 4);
            n_chk++; if (m_out_valid !== ev) begin n_fail++; $display("FAIL midrst_out r=%0d got %b exp %b", r, m_out_valid, ev); end
            if (ev) begin
                n_chk++; if (m_d[3] !== 8'h5E) begin n_fail++; $display("FAIL midrst_data got %h exp 5e", m_d[3]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 8'h00;
        test_reset();
        test_fill();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
